csoc_scan_ctrl: RTL and testbench



---
 rtl/csoc_scan_ctrl_pkg.sv | 25 ++
 rtl/csoc_scan_ctrl_phase_timer.sv | 32 +++
 rtl/csoc_scan_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_csoc_scan_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csoc_scan_ctrl_pkg.sv
// Shared definitions for the CSoC scan-chain sequencer.
//   CMD_OP_W     : width of the command opcode field
//   OP_*         : command opcodes accepted on cmd_op
//   state_t      : sequencer state encoding
package csoc_scan_ctrl_pkg;

  localparam int CMD_OP_W = 2;

  localparam logic [CMD_OP_W-1:0] OP_SHIFT   = 2'b00;
  localparam logic [CMD_OP_W-1:0] OP_CAPTURE = 2'b01;
  localparam logic [CMD_OP_W-1:0] OP_RESET   = 2'b10;
  localparam logic [CMD_OP_W-1:0] OP_SET_TM  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SH_IN    = 3'd1,
    ST_SH_LOW   = 3'd2,
    ST_SH_HIGH  = 3'd3,
    ST_SH_OUT   = 3'd4,
    ST_CAP_LOW  = 3'd5,
    ST_CAP_HIGH = 3'd6,
    ST_RST_HOLD = 3'd7
  } state_t;

endpackage

// File: rtl/csoc_scan_ctrl_phase_timer.sv
// Loadable down-counter timing the csoc_clk phases and the RESET hold.
// Loading N-1 makes the owning state last exactly N cycles: "last" is
// high in the final cycle.
//   clk, rstn  : system clock, asynchronous active-low reset
//   load       : load load_val on this edge (has priority over counting)
//   load_val   : value loaded (cycles remaining minus one)
//   last       : counter has reached zero
module csoc_phase_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         last
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign last = (count_reg == '0);

endmodule

// File: rtl/csoc_scan_ctrl.sv
// Scan-chain sequencer: turns parser commands and a scan-in byte stream
// into registered CSoC test-pin activity, and returns captured scan-out
// bytes. One byte is one shift across 8 parallel chains.
//   clk, rstn                      : system clock, async active-low reset
//   cmd_valid/cmd_ready/op/len     : command handshake from the parser
//   din_valid/din_ready/din        : scan-in byte stream
//   dout_valid/dout_ready/dout     : scan-out byte stream
//   done                           : one-cycle pulse per completed command
//   csoc_clk/rstn/test_se/test_tm  : CSoC control pins (flop outputs)
//   csoc_data_o / csoc_data_i      : scan-in / scan-out chain data
module csoc_scan_ctrl
  import csoc_scan_ctrl_pkg::*;
#(
  parameter int CLK_DIV = 4,
  parameter int LEN_W   = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CMD_OP_W-1:0] cmd_op,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                din_valid,
  output logic                din_ready,
  input  logic [7:0]          din,
  output logic                dout_valid,
  input  logic                dout_ready,
  output logic [7:0]          dout,
  output logic                done,
  output logic                csoc_clk,
  output logic                csoc_rstn,
  output logic                csoc_test_se,
  output logic                csoc_test_tm,
  output logic [7:0]          csoc_data_o,
  input  logic [7:0]          csoc_data_i
);

  // One timer serves both the 8-bit phase count and the LEN_W-wide hold.
  localparam int TW = (LEN_W > 8) ? LEN_W : 8;
  localparam logic [TW-1:0] PHASE_LOAD = TW'(CLK_DIV - 1);

  state_t           state_reg, state_next;
  logic [LEN_W-1:0] remain_reg, remain_next;
  logic [7:0]       capture_reg, capture_next;
  logic [7:0]       dout_reg, dout_next;
  logic             dout_valid_reg, dout_valid_next;
  logic             done_reg, done_next;
  logic             clk_reg, clk_next;
  logic             rstn_pin_reg, rstn_pin_next;
  logic             se_reg, se_next;
  logic             tm_reg, tm_next;
  logic [7:0]       data_o_reg, data_o_next;

  logic             timer_load;
  logic [TW-1:0]    timer_val;
  logic             timer_last;

  csoc_phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rstn     (rstn),
    .load     (timer_load),
    .load_val (timer_val),
    .last     (timer_last)
  );

  always_comb begin
    state_next      = state_reg;
    remain_next     = remain_reg;
    capture_next    = capture_reg;
    dout_next       = dout_reg;
    dout_valid_next = dout_valid_reg;
    done_next       = 1'b0;
    se_next         = se_reg;
    tm_next         = tm_reg;
    data_o_next     = data_o_reg;
    timer_load      = 1'b0;
    timer_val       = PHASE_LOAD;

    case (state_reg)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_SHIFT: begin
              if (cmd_len != '0) begin
                remain_next = cmd_len;
                state_next  = ST_SH_IN;
              end else begin
                done_next = 1'b1;
              end
            end
            OP_CAPTURE: begin
              se_next    = 1'b0;
              timer_load = 1'b1;
              state_next = ST_CAP_LOW;
            end
            OP_RESET: begin
              if (cmd_len != '0) begin
                timer_load = 1'b1;
                timer_val  = TW'(cmd_len - LEN_W'(1));
                state_next = ST_RST_HOLD;
              end else begin
                done_next = 1'b1;
              end
            end
            default: begin  // OP_SET_TM
              tm_next   = cmd_len[0];
              done_next = 1'b1;
            end
          endcase
        end
      end
      ST_SH_IN: begin
        if (din_valid) begin
          data_o_next = din;
          se_next     = 1'b1;
          timer_load  = 1'b1;
          state_next  = ST_SH_LOW;
        end
      end
      ST_SH_LOW: begin
        // Sample the chain outputs just before the rising csoc_clk edge.
        if (timer_last) begin
          capture_next = csoc_data_i;
          timer_load   = 1'b1;
          state_next   = ST_SH_HIGH;
        end
      end
      ST_SH_HIGH: begin
        if (timer_last) begin
          dout_next       = capture_reg;
          dout_valid_next = 1'b1;
          state_next      = ST_SH_OUT;
        end
      end
      ST_SH_OUT: begin
        if (dout_ready) begin
          dout_valid_next = 1'b0;
          // Tested before decrementing so remain never wraps.
          if (remain_reg == LEN_W'(1)) begin
            se_next    = 1'b0;
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            remain_next = remain_reg - LEN_W'(1);
            state_next  = ST_SH_IN;
          end
        end
      end
      ST_CAP_LOW: begin
        if (timer_last) begin
          timer_load = 1'b1;
          state_next = ST_CAP_HIGH;
        end
      end
      ST_CAP_HIGH: begin
        if (timer_last) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_RST_HOLD: begin
        if (timer_last) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // The pin levels follow the state being entered, so the pins stay pure
    // flop outputs while toggling on the same edge as the state change.
    clk_next      = (state_next == ST_SH_HIGH) || (state_next == ST_CAP_HIGH);
    rstn_pin_next = (state_next != ST_RST_HOLD);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg      <= ST_IDLE;
      remain_reg     <= '0;
      capture_reg    <= '0;
      dout_reg       <= '0;
      dout_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      clk_reg        <= 1'b0;
      rstn_pin_reg   <= 1'b0;
      se_reg         <= 1'b0;
      tm_reg         <= 1'b0;
      data_o_reg     <= '0;
    end else begin
      state_reg      <= state_next;
      remain_reg     <= remain_next;
      capture_reg    <= capture_next;
      dout_reg       <= dout_next;
      dout_valid_reg <= dout_valid_next;
      done_reg       <= done_next;
      clk_reg        <= clk_next;
      rstn_pin_reg   <= rstn_pin_next;
      se_reg         <= se_next;
      tm_reg         <= tm_next;
      data_o_reg     <= data_o_next;
    end
  end

  assign cmd_ready    = (state_reg == ST_IDLE);
  assign din_ready    = (state_reg == ST_SH_IN);
  assign dout_valid   = dout_valid_reg;
  assign dout         = dout_reg;
  assign done         = done_reg;
  assign csoc_clk     = clk_reg;
  assign csoc_rstn    = rstn_pin_reg;
  assign csoc_test_se = se_reg;
  assign csoc_test_tm = tm_reg;
  assign csoc_data_o  = data_o_reg;

endmodule

// File: tb/tb_csoc_scan_ctrl.sv
// Directed + randomized bench for csoc_scan_ctrl. The CSoC is modelled as
// eight 1-flop scan chains clocked by csoc_clk; the reference model treats
// each burst as a 1-deep shift register: bytes out = previous byte, then
// every byte in except the last.
module tb_csoc_scan_ctrl;
  import csoc_scan_ctrl_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int LEN_W    = 16;
  localparam int BYTE_CYC = 2 * CLK_DIV + 2;

  logic             clk = 1'b0;
  logic             rstn = 1'b1;
  logic             cmd_valid = 1'b0, cmd_ready;
  logic [1:0]       cmd_op = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             din_valid = 1'b0, din_ready;
  logic [7:0]       din = '0;
  logic             dout_valid, dout_ready = 1'b0;
  logic [7:0]       dout;
  logic             done;
  logic             csoc_clk, csoc_rstn, csoc_test_se, csoc_test_tm;
  logic [7:0]       csoc_data_o, csoc_data_i;

  csoc_scan_ctrl #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .din_valid(din_valid), .din_ready(din_ready), .din(din),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout(dout),
    .done(done),
    .csoc_clk(csoc_clk), .csoc_rstn(csoc_rstn), .csoc_test_se(csoc_test_se),
    .csoc_test_tm(csoc_test_tm), .csoc_data_o(csoc_data_o), .csoc_data_i(csoc_data_i)
  );

  always #5 clk = ~clk;

  // Circuit under test: one flop per chain.
  logic [7:0] cut_q = 8'h00;
  always @(posedge csoc_clk) cut_q <= csoc_data_o;
  assign csoc_data_i = cut_q;

  // Passive monitors.
  int cyc = 0;
  int rise_cnt = 0;
  int done_cnt = 0;
  int hi_run = 0;
  int hi_widths[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge csoc_clk) rise_cnt <= rise_cnt + 1;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (csoc_clk) hi_run <= hi_run + 1;
    else if (hi_run != 0) begin
      hi_widths.push_back(hi_run);
      hi_run <= 0;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model state.
  logic [7:0] cut_model = 8'h00;
  logic       tm_model  = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] got_q[$];
  int         din_cyc_q[$];
  int         dout_cyc_q[$];
  int         done_cyc, stall_viol, se_viol;
  logic       se_at_done;

  // Called at posedge+1; returns at posedge+1 right after acceptance.
  task automatic send_cmd(input logic [1:0] op, input logic [LEN_W-1:0] len);
    int t = 0;
    while (!cmd_ready && t < 500) begin
      @(posedge clk); #1; t++;
    end
    check("cmd_ready_before_cmd", 32'(t < 500), 1);
    cmd_op = op; cmd_len = len; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int n_cyc, output int n_rst_lo,
                                output int n_clk_hi, output int n_se_hi, output int n_busy,
                                output int n_stream, output bit ok);
    n_cyc = 0; n_rst_lo = 0; n_clk_hi = 0; n_se_hi = 0; n_busy = 0; n_stream = 0; ok = 0;
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      if (done) begin ok = 1; break; end
      n_cyc++;
      if (!csoc_rstn) n_rst_lo++;
      if (csoc_clk) n_clk_hi++;
      if (csoc_test_se) n_se_hi++;
      if (cmd_ready) n_busy++;
      if (din_ready || dout_valid) n_stream++;
    end
    @(posedge clk); #1;
  endtask

  // mode 0: no stalls; 1: dout_ready low for 20 cycles after first dout; 2: random.
  task automatic run_shift(input int n, input int mode);
    int  sent = 0;
    int  stall_left = 0;
    bit  stall_started = 0;
    got_q.delete(); din_cyc_q.delete(); dout_cyc_q.delete();
    stall_viol = 0; se_viol = 0; done_cyc = -1; se_at_done = 1'b1;
    din_valid = 1'b1; din = tx_q[0];
    dout_ready = (mode == 0);
    for (int t = 0; t < 3000; t++) begin
      @(negedge clk);
      if (done) begin done_cyc = cyc; se_at_done = csoc_test_se; break; end
      if (din_cyc_q.size() > 0 && !csoc_test_se) se_viol++;
      if (mode == 1 && dout_valid && !stall_started) begin
        stall_started = 1; stall_left = 20;
      end
      if (mode == 1 && stall_started && stall_left > 0)
        if (csoc_clk !== 1'b0 || csoc_data_o !== tx_q[0] || din_ready !== 1'b0) stall_viol++;
      if (din_valid && din_ready) begin din_cyc_q.push_back(cyc); sent++; end
      if (dout_valid && dout_ready) begin got_q.push_back(dout); dout_cyc_q.push_back(cyc); end
      @(posedge clk); #1;
      din_valid = (sent < n) && (mode != 2 || $urandom_range(0, 3) != 0);
      if (sent < n) din = tx_q[sent];
      case (mode)
        0: dout_ready = 1'b1;
        1: begin
          if (stall_started && stall_left > 0) stall_left--;
          dout_ready = stall_started && (stall_left == 0);
        end
        default: dout_ready = ($urandom_range(0, 9) < 6);
      endcase
    end
    din_valid = 1'b0; dout_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full SHIFT command with model-based checks of data, pins and done.
  task automatic shift_burst(input string tag, input int n, input int mode);
    int rise0 = rise_cnt, done0 = done_cnt, hi0 = hi_widths.size();
    logic [7:0] expq[$];
    expq.push_back(cut_model);
    for (int i = 0; i + 1 < n; i++) expq.push_back(tx_q[i]);
    send_cmd(OP_SHIFT, LEN_W'(n));
    run_shift(n, mode);
    check({tag, "_done_seen"}, 32'(done_cyc != -1), 1);
    check({tag, "_dout_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check($sformatf("%s_dout%0d", tag, i), got_q[i], expq[i]);
    check({tag, "_clk_rises"}, rise_cnt - rise0, n);
    for (int i = hi0; i < hi_widths.size(); i++)
      check($sformatf("%s_clk_high_width%0d", tag, i - hi0), hi_widths[i], CLK_DIV);
    check({tag, "_se_during_burst"}, se_viol, 0);
    check({tag, "_se_after_done"}, se_at_done, 0);
    check({tag, "_done_pulses"}, done_cnt - done0, 1);
    check({tag, "_tm_persist"}, csoc_test_tm, tm_model);
    cut_model = tx_q[n - 1];
  endtask

  initial begin
    int  n_cyc, n_rst_lo, n_clk_hi, n_se_hi, n_busy, n_stream, rise0, done0, cnt;
    bit  ok;

    // ---- reset values (checked while reset is held) ----
    #1 rstn = 1'b0;
    #21;
    check("rst_csoc_clk", csoc_clk, 0);
    check("rst_csoc_rstn", csoc_rstn, 0);
    check("rst_se", csoc_test_se, 0);
    check("rst_tm", csoc_test_tm, 0);
    check("rst_data_o", csoc_data_o, 0);
    check("rst_dout", dout, 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_din_ready", din_ready, 0);
    check("rst_done", done, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    #15 rstn = 1'b1;                      // released between edges
    #2 check("rstn_pin_before_edge", csoc_rstn, 0);
    @(posedge clk); #1;
    check("rstn_pin_first_edge", csoc_rstn, 1);

    // ---- SET_TM 1 then 0 ----
    rise0 = rise_cnt;
    send_cmd(OP_SET_TM, 16'd1);
    check("settm1_done", done, 1);
    check("settm1_tm", csoc_test_tm, 1);
    @(posedge clk); #1;
    check("settm1_done_one_cycle", done, 0);
    send_cmd(OP_SET_TM, 16'd0);
    check("settm0_done", done, 1);
    check("settm0_tm", csoc_test_tm, 0);
    @(posedge clk); #1;
    check("settm0_done_one_cycle", done, 0);
    check("settm_no_clk", rise_cnt - rise0, 0);

    // ---- SHIFT 3, no stalls, fixed data ----
    tx_q = '{8'hA5, 8'h3C, 8'hFF};
    shift_burst("shift3", 3, 0);
    check("shift3_dout_vals", {got_q[0], got_q[1], got_q[2]}, 24'h00A53C);
    check("shift3_cycles", done_cyc - din_cyc_q[0], 3 * BYTE_CYC);

    // ---- SHIFT 2 with a 20-cycle dout stall ----
    tx_q = '{8'($urandom), 8'($urandom)};
    shift_burst("stall2", 2, 1);
    check("stall2_hold_violations", stall_viol, 0);
    check("stall2_din2_after_dout1",
          32'(din_cyc_q.size() == 2 && dout_cyc_q.size() >= 1 && din_cyc_q[1] > dout_cyc_q[0]), 1);

    // ---- CAPTURE ----
    rise0 = rise_cnt; done0 = done_cnt;
    send_cmd(OP_CAPTURE, 16'($urandom));
    run_until_done(200, n_cyc, n_rst_lo, n_clk_hi, n_se_hi, n_busy, n_stream, ok);
    check("cap_done_seen", ok, 1);
    check("cap_cycles", n_cyc, 2 * CLK_DIV);
    check("cap_clk_high", n_clk_hi, CLK_DIV);
    check("cap_se_low", n_se_hi, 0);
    check("cap_no_stream", n_stream, 0);
    check("cap_clk_rises", rise_cnt - rise0, 1);
    check("cap_done_pulses", done_cnt - done0, 1);
    cut_model = tx_q[1];                  // capture clocks the last scan-in byte again

    // ---- RESET 7 ----
    send_cmd(OP_RESET, 16'd7);
    run_until_done(200, n_cyc, n_rst_lo, n_clk_hi, n_se_hi, n_busy, n_stream, ok);
    check("rst7_done_seen", ok, 1);
    check("rst7_rstn_low", n_rst_lo, 7);
    check("rst7_cmd_ready_low", n_busy, 0);
    check("rst7_clk_low", n_clk_hi, 0);
    check("rst7_rstn_after", csoc_rstn, 1);

    // ---- zero-length SHIFT and RESET ----
    rise0 = rise_cnt;
    send_cmd(OP_SHIFT, 16'd0);
    run_until_done(20, n_cyc, n_rst_lo, n_clk_hi, n_se_hi, n_busy, n_stream, ok);
    check("shift0_immediate_done", 32'(ok && n_cyc == 0), 1);
    send_cmd(OP_RESET, 16'd0);
    run_until_done(20, n_cyc, n_rst_lo, n_clk_hi, n_se_hi, n_busy, n_stream, ok);
    check("reset0_immediate_done", 32'(ok && n_cyc == 0 && n_rst_lo == 0), 1);
    check("zero_len_no_clk", rise_cnt - rise0, 0);

    // ---- reset in the middle of SH_HIGH of a SHIFT 5 ----
    send_cmd(OP_SET_TM, 16'd1);
    tx_q.delete();
    for (int i = 0; i < 5; i++) tx_q.push_back(8'($urandom_range(1, 255)));
    send_cmd(OP_SHIFT, 16'd5);
    din_valid = 1'b1; din = tx_q[0]; dout_ready = 1'b1;
    ok = 0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (csoc_clk) begin ok = 1; break; end
    end
    check("abort_reached_high", ok, 1);
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    check("abort_clk", csoc_clk, 0);
    check("abort_se", csoc_test_se, 0);
    check("abort_data_o", csoc_data_o, 0);
    check("abort_rstn_pin", csoc_rstn, 0);
    check("abort_tm", csoc_test_tm, 0);
    check("abort_dout_valid", dout_valid, 0);
    din_valid = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    rstn = 1'b1;
    @(posedge clk); #1;
    check("abort_release_rstn_pin", csoc_rstn, 1);
    check("abort_release_cmd_ready", cmd_ready, 1);
    cnt = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      if (dout_valid || csoc_clk || dout != 8'h00) cnt++;
    end
    check("abort_no_stale_dout", cnt, 0);
    @(posedge clk); #1;
    tm_model  = 1'b0;
    cut_model = tx_q[0];                  // byte 0 was clocked before the abort

    // ---- randomized bursts ----
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        tm_model = 1'($urandom);
        send_cmd(OP_SET_TM, {15'($urandom), tm_model});
        @(posedge clk); #1;
      end
      tx_q.delete();
      cnt = $urandom_range(1, 6);
      for (int i = 0; i < cnt; i++) tx_q.push_back(8'($urandom));
      shift_burst($sformatf("rand%0d", it), cnt, 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
